// File: rtl/read_return_collector.sv
// rtl/read_return_collector.sv - east-end read-data chain terminator: per-lane FIFOs drained by a round-robin response port
// No backpressure reaches the chain; each popped entry returns one credit to the upstream read arbiter.

package read_return_collector_pkg;
   typedef struct packed {
      logic [31:0] data;
      logic [15:0] cmd_pld;
   } data_pld_t;
endpackage

module read_return_collector
   import read_return_collector_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_LANE   = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_LANE-1:0]           data_in_vld,
   input  data_pld_t [NUM_LANE-1:0]      data_in,
   output logic                          rd_resp_vld,
   input  logic                          rd_resp_rdy,
   output data_pld_t                     rd_resp_pld,
   output logic [$clog2(NUM_LANE)-1:0]   rd_resp_lane,
   output logic [NUM_LANE-1:0]           credit_rel,
   output logic [NUM_LANE-1:0]           overflow_err,
   output logic [NUM_LANE-1:0]           fifo_empty
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int LANE_W = $clog2(NUM_LANE);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   data_pld_t          mem    [NUM_LANE][FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr [NUM_LANE];
   logic [PTR_W-1:0]   rd_ptr [NUM_LANE];
   logic [CNT_W-1:0]   count  [NUM_LANE];

   logic [NUM_LANE-1:0] nonempty;
   logic [NUM_LANE-1:0] full;
   logic [NUM_LANE-1:0] push;
   logic [NUM_LANE-1:0] pop;

   logic [LANE_W-1:0]   rr_ptr;
   logic [LANE_W-1:0]   rr_grant;
   logic [LANE_W-1:0]   rr_idx;
   logic                rr_found;
   logic [LANE_W-1:0]   grant;
   logic [LANE_W-1:0]   lock_lane;
   logic                lock_vld;
   logic                handshake;

   always_comb begin
      for (int i = 0; i < NUM_LANE; i++) begin
         nonempty[i] = (count[i] != '0);
         full[i]     = (count[i] == FULL_CNT);
      end
   end

   assign fifo_empty = ~nonempty;
   assign rd_resp_vld = |nonempty;

   // First non-empty lane at or after rr_ptr, wrapping.
   always_comb begin
      rr_grant = rr_ptr;
      rr_idx   = '0;
      rr_found = 1'b0;
      for (int k = 0; k < NUM_LANE; k++) begin
         rr_idx = rr_ptr + LANE_W'(k);
         if (!rr_found && nonempty[rr_idx]) begin
            rr_grant = rr_idx;
            rr_found = 1'b1;
         end
      end
   end

   // A stalled grant is frozen so pld/lane stay stable until the handshake.
   assign grant     = lock_vld ? lock_lane : rr_grant;
   assign handshake = rd_resp_vld && rd_resp_rdy;

   always_comb begin
      for (int i = 0; i < NUM_LANE; i++) begin
         pop[i]  = handshake && (grant == LANE_W'(i));
         push[i] = data_in_vld[i] && (!full[i] || pop[i]);
      end
   end

   assign rd_resp_pld  = rd_resp_vld ? mem[grant][rd_ptr[grant]] : '0;
   assign rd_resp_lane = rd_resp_vld ? grant : '0;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_LANE; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i]] <= data_in[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LANE; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         overflow_err <= '0;
      end else begin
         for (int i = 0; i < NUM_LANE; i++) begin
            if (push[i]) begin
               wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            end
            if (pop[i]) begin
               rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            end
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + CNT_W'(1);
               2'b01:   count[i] <= count[i] - CNT_W'(1);
               default: count[i] <= count[i];
            endcase
            if (data_in_vld[i] && !push[i]) begin
               overflow_err[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         lock_vld   <= 1'b0;
         lock_lane  <= '0;
         credit_rel <= '0;
      end else begin
         credit_rel <= pop;
         if (handshake) begin
            rr_ptr   <= grant + LANE_W'(1);
            lock_vld <= 1'b0;
         end else if (rd_resp_vld) begin
            lock_vld  <= 1'b1;
            lock_lane <= grant;
         end
      end
   end

endmodule

// File: tb/tb_read_return_collector.sv
// tb/tb_read_return_collector.sv - self-checking bench for read_return_collector against a queue-based model
module tb_read_return_collector;
   import read_return_collector_pkg::*;

   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [7:0]      data_in_vld;
   data_pld_t [7:0] data_in;
   logic            rd_resp_vld;
   logic            rd_resp_rdy;
   data_pld_t       rd_resp_pld;
   logic [2:0]      rd_resp_lane;
   logic [7:0]      credit_rel;
   logic [7:0]      overflow_err;
   logic [7:0]      fifo_empty;

   read_return_collector #(.FIFO_DEPTH(DEPTH), .NUM_LANE(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in_vld  (data_in_vld),
      .data_in      (data_in),
      .rd_resp_vld  (rd_resp_vld),
      .rd_resp_rdy  (rd_resp_rdy),
      .rd_resp_pld  (rd_resp_pld),
      .rd_resp_lane (rd_resp_lane),
      .credit_rel   (credit_rel),
      .overflow_err (overflow_err),
      .fifo_empty   (fifo_empty)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   data_pld_t [7:0] din;
   data_pld_t       mq [8][$];
   int              m_rr;
   int              m_held;
   logic [7:0]      m_credit;
   logic [7:0]      m_ovf;

   function automatic data_pld_t rand_pld();
      data_pld_t p;
      p.data    = $urandom;
      p.cmd_pld = 16'($urandom);
      return p;
   endfunction

   function automatic int m_lane();
      if (m_held >= 0) return m_held;
      for (int k = 0; k < 8; k++)
         if (mq[(m_rr + k) % 8].size() != 0) return (m_rr + k) % 8;
      return -1;
   endfunction

   function automatic logic [7:0] m_empty();
      logic [7:0] e;
      for (int i = 0; i < 8; i++) e[i] = (mq[i].size() == 0);
      return e;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 8; i++) mq[i].delete();
      m_rr = 0; m_held = -1; m_credit = '0; m_ovf = '0;
   endtask

   // Model of one clock edge: present, maybe pop, then pushes (an arriving beat is never presented this cycle).
   task automatic model_clock(input logic [7:0] vld, input logic rdy);
      int g;
      g = m_lane();
      m_credit = '0;
      if (g >= 0 && rdy) begin
         void'(mq[g].pop_front());
         m_credit[g] = 1'b1;
         m_rr = (g + 1) % 8;
         m_held = -1;
      end else if (g >= 0) begin
         m_held = g;
      end
      for (int i = 0; i < 8; i++)
         if (vld[i]) begin
            if (mq[i].size() < DEPTH) mq[i].push_back(din[i]);
            else m_ovf[i] = 1'b1;
         end
   endtask

   task automatic drive_cycle(input logic [7:0] vld, input logic rdy);
      data_in_vld = vld;
      rd_resp_rdy = rdy;
      data_in     = din;
      model_clock(vld, rdy);
      @(posedge clk);
      @(negedge clk);
      data_in_vld = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      data_in_vld = '0;
      rd_resp_rdy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (rd_resp_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", rd_resp_vld); end
      n_checks++; if (rd_resp_lane !== 3'd0) begin n_fail++; $display("FAIL reset_lane: got %0d want 0", rd_resp_lane); end
      n_checks++; if (rd_resp_pld !== '0) begin n_fail++; $display("FAIL reset_pld: got %h want 0", rd_resp_pld); end
      n_checks++; if (credit_rel !== 8'h00) begin n_fail++; $display("FAIL reset_credit: got %h want 00", credit_rel); end
      n_checks++; if (overflow_err !== 8'h00) begin n_fail++; $display("FAIL reset_ovf: got %h want 00", overflow_err); end
      n_checks++; if (fifo_empty !== 8'hFF) begin n_fail++; $display("FAIL reset_empty: got %h want FF", fifo_empty); end
      rst_n = 1'b1;
      m_reset();
   endtask

   task automatic test_single_beat();
      apply_reset();
      din = '0;
      din[5].data = 32'hA5A5_0001;
      drive_cycle(8'h20, 1'b1);
      n_checks++; if (rd_resp_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld: got %b want 1", rd_resp_vld); end
      n_checks++; if (rd_resp_lane !== 3'd5) begin n_fail++; $display("FAIL single_lane: got %0d want 5", rd_resp_lane); end
      n_checks++; if (rd_resp_pld.data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_data: got %h want A5A50001", rd_resp_pld.data); end
      n_checks++; if (credit_rel !== 8'h00) begin n_fail++; $display("FAIL single_credit_early: got %h want 00", credit_rel); end
      drive_cycle(8'h00, 1'b1);
      n_checks++; if (credit_rel !== 8'h20) begin n_fail++; $display("FAIL single_credit: got %h want 20", credit_rel); end
      n_checks++; if (fifo_empty !== 8'hFF) begin n_fail++; $display("FAIL single_empty: got %h want FF", fifo_empty); end
      n_checks++; if (rd_resp_vld !== 1'b0) begin n_fail++; $display("FAIL single_vld_after: got %b want 0", rd_resp_vld); end
   endtask

   task automatic test_all_lanes();
      data_pld_t exp_p;
      logic [7:0] exp_c;
      apply_reset();
      for (int i = 0; i < 8; i++) din[i] = rand_pld();
      drive_cycle(8'hFF, 1'b1);
      for (int k = 0; k < 8; k++) begin
         exp_p = mq[k][0];
         exp_c = (k == 0) ? 8'h00 : 8'(1 << (k - 1));
         n_checks++; if (rd_resp_lane !== 3'(k)) begin n_fail++; $display("FAIL all_lane[%0d]: got %0d want %0d", k, rd_resp_lane, k); end
         n_checks++; if (rd_resp_pld !== exp_p) begin n_fail++; $display("FAIL all_pld[%0d]: got %h want %h", k, rd_resp_pld, exp_p); end
         n_checks++; if (credit_rel !== exp_c) begin n_fail++; $display("FAIL all_credit[%0d]: got %h want %h", k, credit_rel, exp_c); end
         drive_cycle(8'h00, 1'b1);
      end
      n_checks++; if (credit_rel !== 8'h80) begin n_fail++; $display("FAIL all_credit_last: got %h want 80", credit_rel); end
      n_checks++; if (fifo_empty !== 8'hFF) begin n_fail++; $display("FAIL all_empty: got %h want FF", fifo_empty); end
   endtask

   task automatic test_grant_lock();
      data_pld_t p2;
      int order [3] = '{2, 6, 0};
      apply_reset();
      for (int i = 0; i < 8; i++) din[i] = rand_pld();
      p2 = din[2];
      drive_cycle(8'h44, 1'b0);
      for (int j = 0; j < 5; j++) begin
         n_checks++; if (rd_resp_lane !== 3'd2) begin n_fail++; $display("FAIL lock_lane[%0d]: got %0d want 2", j, rd_resp_lane); end
         n_checks++; if (rd_resp_pld !== p2) begin n_fail++; $display("FAIL lock_pld[%0d]: got %h want %h", j, rd_resp_pld, p2); end
         if (j == 4) din[0] = rand_pld();
         drive_cycle((j == 4) ? 8'h01 : 8'h00, 1'b0);
      end
      n_checks++; if (rd_resp_lane !== 3'd2) begin n_fail++; $display("FAIL lock_after_fill: got %0d want 2", rd_resp_lane); end
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (rd_resp_lane !== 3'(order[k])) begin n_fail++; $display("FAIL lock_order[%0d]: got %0d want %0d", k, rd_resp_lane, order[k]); end
         drive_cycle(8'h00, 1'b1);
      end
      n_checks++; if (rd_resp_vld !== 1'b0) begin n_fail++; $display("FAIL lock_drained: got %b want 0", rd_resp_vld); end
   endtask

   task automatic test_overflow();
      data_pld_t b [5];
      int credits = 0;
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         b[k] = rand_pld();
         din[3] = b[k];
         drive_cycle(8'h08, 1'b0);
      end
      n_checks++; if (overflow_err !== 8'h08) begin n_fail++; $display("FAIL ovf_flag: got %h want 08", overflow_err); end
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (rd_resp_pld !== b[k]) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h want %h", k, rd_resp_pld, b[k]); end
         drive_cycle(8'h00, 1'b1);
         if (credit_rel == 8'h08) credits++;
      end
      n_checks++; if (credits !== 4) begin n_fail++; $display("FAIL ovf_credits: got %0d want 4", credits); end
      n_checks++; if (rd_resp_vld !== 1'b0) begin n_fail++; $display("FAIL ovf_extra: got %b want 0", rd_resp_vld); end
      n_checks++; if (overflow_err !== 8'h08) begin n_fail++; $display("FAIL ovf_sticky: got %h want 08", overflow_err); end
   endtask

   task automatic test_full_concurrent();
      data_pld_t b [5];
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         b[k] = rand_pld();
         din[1] = b[k];
         drive_cycle(8'h02, 1'b0);
      end
      b[4] = rand_pld();
      din[1] = b[4];
      drive_cycle(8'h02, 1'b1);
      n_checks++; if (overflow_err !== 8'h00) begin n_fail++; $display("FAIL full_pop_ovf: got %h want 00", overflow_err); end
      for (int k = 1; k < 5; k++) begin
         n_checks++; if (rd_resp_pld !== b[k]) begin n_fail++; $display("FAIL full_pop_order[%0d]: got %h want %h", k, rd_resp_pld, b[k]); end
         drive_cycle(8'h00, 1'b1);
      end
      n_checks++; if (rd_resp_vld !== 1'b0) begin n_fail++; $display("FAIL full_pop_count: got %b want 0", rd_resp_vld); end
   endtask

   task automatic test_reset_mid_drain();
      data_pld_t p;
      apply_reset();
      for (int i = 0; i < 8; i++) din[i] = rand_pld();
      drive_cycle(8'h0E, 1'b0);
      rst_n = 1'b0;
      #1;
      n_checks++; if (rd_resp_vld !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vld: got %b want 0", rd_resp_vld); end
      n_checks++; if (rd_resp_pld !== '0) begin n_fail++; $display("FAIL mid_rst_pld: got %h want 0", rd_resp_pld); end
      n_checks++; if (rd_resp_lane !== 3'd0) begin n_fail++; $display("FAIL mid_rst_lane: got %0d want 0", rd_resp_lane); end
      n_checks++; if (fifo_empty !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_empty: got %h want FF", fifo_empty); end
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (credit_rel !== 8'h00) begin n_fail++; $display("FAIL mid_rst_credit: got %h want 00", credit_rel); end
      rst_n = 1'b1;
      m_reset();
      drive_cycle(8'h00, 1'b1);
      n_checks++; if (credit_rel !== 8'h00) begin n_fail++; $display("FAIL mid_rst_credit_after: got %h want 00", credit_rel); end
      din[7] = rand_pld();
      p = din[7];
      drive_cycle(8'h80, 1'b1);
      n_checks++; if (rd_resp_lane !== 3'd7 || rd_resp_pld !== p) begin n_fail++; $display("FAIL mid_rst_new: got lane %0d %h want lane 7 %h", rd_resp_lane, rd_resp_pld, p); end
      drive_cycle(8'h00, 1'b1);
   endtask

   task automatic test_random();
      int g;
      logic [7:0] vld;
      logic [7:0] exp_e;
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         g = m_lane();
         exp_e = m_empty();
         n_checks++; if (rd_resp_vld !== 1'(g >= 0)) begin n_fail++; $display("FAIL rnd_vld@%0d: got %b want %b", c, rd_resp_vld, g >= 0); end
         if (g >= 0) begin
            n_checks++; if (rd_resp_lane !== 3'(g)) begin n_fail++; $display("FAIL rnd_lane@%0d: got %0d want %0d", c, rd_resp_lane, g); end
            n_checks++; if (rd_resp_pld !== mq[g][0]) begin n_fail++; $display("FAIL rnd_pld@%0d: got %h want %h", c, rd_resp_pld, mq[g][0]); end
         end
         n_checks++; if (credit_rel !== m_credit) begin n_fail++; $display("FAIL rnd_credit@%0d: got %h want %h", c, credit_rel, m_credit); end
         n_checks++; if (overflow_err !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %h want %h", c, overflow_err, m_ovf); end
         n_checks++; if (fifo_empty !== exp_e) begin n_fail++; $display("FAIL rnd_empty@%0d: got %h want %h", c, fifo_empty, exp_e); end
         for (int i = 0; i < 8; i++) begin
            din[i] = rand_pld();
            vld[i] = (c < 300) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 5) == 0);
         end
         drive_cycle(vld, $urandom_range(0, 9) < 7);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      data_in_vld = '0;
      rd_resp_rdy = 1'b0;
      din = '0;
      data_in = '0;
      m_reset();
      test_reset();
      test_single_beat();
      test_all_lanes();
      test_grant_lock();
      test_overflow();
      test_full_concurrent();
      test_reset_mid_drain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
